// File: rtl/kernel_irq_helper_if.sv
// AXI-lite bundle (32-bit data, parameterised address) used on both the
// infrastructure side and the kernel side of kernel_irq_helper.
interface kernel_irq_helper_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/kernel_irq_helper.sv
// Multi-channel kernel interrupt helper: per-line edge detect, pending bits,
// round-robin req/ack handshake, and a special register window overlaid on AXI-lite.
module kernel_irq_helper #(
  parameter int unsigned NUM_IRQ                    = 4,
  parameter logic [31:0] KERNEL_TYPE                = 32'h0000ABCD,
  parameter logic [31:0] RELEASE_LEVEL              = 32'h00000001,
  parameter logic [31:0] SPECIAL_REG_BASE           = 32'h00010000,
  parameter int unsigned CTXW                       = 9,
  parameter int unsigned C_S_AXI_CONTROL_ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_IRQ-1:0]  interrupt_i,
  output logic                interrupt_req,
  output logic [63:0]         interrupt_src,
  output logic [CTXW-1:0]     interrupt_ctx,
  input  logic                interrupt_ack,
  kernel_irq_helper_if.slave  s_axilite,
  kernel_irq_helper_if.master s_axi_control
);

  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] OFF_TYPE    = 32'h10;
  localparam logic [31:0] OFF_RELEASE = 32'h14;
  localparam logic [31:0] OFF_SRC_LO  = 32'h18;
  localparam logic [31:0] OFF_SRC_HI  = 32'h1C;
  localparam logic [31:0] OFF_CONTEXT = 32'h20;
  localparam logic [31:0] OFF_IRQ_EN  = 32'h24;
  localparam logic [31:0] OFF_PEND    = 32'h28;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state;
  logic               aw_hs, w_hs, ar_hs;
  logic [31:0]        aw_addr_q, ar_addr_q, wr_addr, wr_off, rd_off;
  logic [31:0]        src_lo, src_hi, reg_context, hijack;
  logic [NUM_IRQ-1:0] irq_en, irq_q, rise, pend, cand, pend_w1c, grant_clr;
  logic [IW-1:0]      last_grant, grant_idx;
  logic               grant_found;
  int unsigned        rr_idx;

  // Straight pass-through between infrastructure and kernel
  assign s_axi_control.awaddr  = s_axilite.awaddr[C_S_AXI_CONTROL_ADDR_WIDTH-1:0];
  assign s_axi_control.awvalid = s_axilite.awvalid;
  assign s_axi_control.wdata   = s_axilite.wdata;
  assign s_axi_control.wstrb   = s_axilite.wstrb;
  assign s_axi_control.wvalid  = s_axilite.wvalid;
  assign s_axi_control.bready  = s_axilite.bready;
  assign s_axi_control.araddr  = s_axilite.araddr[C_S_AXI_CONTROL_ADDR_WIDTH-1:0];
  assign s_axi_control.arvalid = s_axilite.arvalid;
  assign s_axi_control.rready  = s_axilite.rready;
  assign s_axilite.awready     = s_axi_control.awready;
  assign s_axilite.wready      = s_axi_control.wready;
  assign s_axilite.bresp       = s_axi_control.bresp;
  assign s_axilite.bvalid      = s_axi_control.bvalid;
  assign s_axilite.arready     = s_axi_control.arready;
  assign s_axilite.rresp       = s_axi_control.rresp;
  assign s_axilite.rvalid      = s_axi_control.rvalid;
  assign s_axilite.rdata       = s_axi_control.rdata | hijack;

  assign aw_hs   = s_axilite.awvalid & s_axi_control.awready;
  assign w_hs    = s_axilite.wvalid  & s_axi_control.wready;
  assign ar_hs   = s_axilite.arvalid & s_axi_control.arready;
  assign wr_addr = aw_hs ? s_axilite.awaddr : aw_addr_q;
  assign wr_off  = wr_addr - SPECIAL_REG_BASE;
  assign rd_off  = ar_addr_q - SPECIAL_REG_BASE;

  assign pend_w1c      = (w_hs && wr_off == OFF_PEND) ? s_axilite.wdata[NUM_IRQ-1:0] : '0;
  assign interrupt_ctx = reg_context[CTXW-1:0];
  assign rise          = interrupt_i & ~irq_q;
  assign cand          = pend & irq_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      src_lo      <= '0;
      src_hi      <= '0;
      reg_context <= '0;
      irq_en      <= '1;
    end else begin
      if (aw_hs) aw_addr_q <= s_axilite.awaddr;
      if (ar_hs) ar_addr_q <= s_axilite.araddr;
      if (w_hs) begin
        case (wr_off)
          OFF_SRC_LO:  src_lo      <= s_axilite.wdata;
          OFF_SRC_HI:  src_hi      <= s_axilite.wdata;
          OFF_CONTEXT: reg_context <= s_axilite.wdata;
          OFF_IRQ_EN:  irq_en      <= s_axilite.wdata[NUM_IRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hijack = '0;
    if (s_axi_control.rvalid) begin
      case (rd_off)
        OFF_TYPE:    hijack = KERNEL_TYPE;
        OFF_RELEASE: hijack = RELEASE_LEVEL;
        OFF_CONTEXT: hijack = reg_context;
        OFF_IRQ_EN:  hijack = 32'(irq_en);
        OFF_PEND:    hijack = 32'(pend);
        default:     hijack = '0;
      endcase
    end
  end

  // Round-robin: scan from last_grant+1, wrapping once around NUM_IRQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      rr_idx = 32'(last_grant) + 32'd1 + i;
      if (rr_idx >= NUM_IRQ) rr_idx = rr_idx - NUM_IRQ;
      if (!grant_found && cand[IW'(rr_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(rr_idx);
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (state == S_IDLE && grant_found) grant_clr[grant_idx] = 1'b1;
  end

  // A fresh edge re-arms pend even on the bit being cleared by grant or W1C
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      interrupt_req <= 1'b0;
      interrupt_src <= '0;
      pend          <= '0;
      irq_q         <= '0;
      last_grant    <= IW'(NUM_IRQ - 1);
    end else begin
      irq_q         <= interrupt_i;
      pend          <= (pend & ~pend_w1c & ~grant_clr) | rise;
      interrupt_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            state         <= S_REQ;
            interrupt_req <= 1'b1;
            interrupt_src <= {src_hi, src_lo} + 64'(grant_idx);
            last_grant    <= grant_idx;
          end
        end
        S_REQ:   state <= interrupt_ack ? S_IDLE : S_WAIT;
        S_WAIT:  if (interrupt_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_irq_helper.sv
// Directed plus randomized bench for kernel_irq_helper with a round-robin
// reference model kept at the level of "pending set ordered by rotated distance".
module tb_kernel_irq_helper;
  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   interrupt_i = '0;
  logic           interrupt_req;
  logic [63:0]    interrupt_src;
  logic [8:0]     interrupt_ctx;
  logic           interrupt_ack = 1'b0;

  kernel_irq_helper_if #(.ADDR_W(32)) axil ();
  kernel_irq_helper_if #(.ADDR_W(32)) ctl ();

  int           checks = 0;
  int           errors = 0;
  int unsigned  rr_last = N - 1;
  logic [63:0]  src_base = '0;
  int unsigned  order_q[$];

  kernel_irq_helper #(
    .NUM_IRQ(N),
    .KERNEL_TYPE(32'h0000ABCD),
    .RELEASE_LEVEL(32'h00000001),
    .SPECIAL_REG_BASE(BASE),
    .CTXW(9),
    .C_S_AXI_CONTROL_ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .interrupt_i(interrupt_i),
    .interrupt_req(interrupt_req),
    .interrupt_src(interrupt_src),
    .interrupt_ctx(interrupt_ctx),
    .interrupt_ack(interrupt_ack),
    .s_axilite(axil),
    .s_axi_control(ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int unsigned cycles);
    resetn = 1'b0;
    repeat (cycles) @(negedge clk);
    resetn   = 1'b1;
    rr_last  = N - 1;
    src_base = '0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input bit split, input logic [N-1:0] irqm);
    axil.awaddr  = addr;
    axil.awvalid = 1'b1;
    if (split) begin
      @(negedge clk);
      axil.awvalid = 1'b0;
      axil.awaddr  = 32'hDEAD_0000;
    end
    axil.wdata  = data;
    axil.wvalid = 1'b1;
    interrupt_i = irqm;
    @(negedge clk);
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    interrupt_i  = '0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] kdata,
                          output logic [31:0] rd);
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    #1;
    check("araddr_pass", ctl.araddr, addr);
    @(negedge clk);
    axil.arvalid = 1'b0;
    ctl.rvalid   = 1'b1;
    ctl.rdata    = kdata;
    #1;
    rd = axil.rdata;
    @(negedge clk);
    ctl.rvalid = 1'b0;
    ctl.rdata  = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    axi_read(addr, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic pulse_irq(input logic [N-1:0] m);
    interrupt_i = m;
    @(negedge clk);
    interrupt_i = '0;
  endtask

  task automatic wait_req(output int unsigned n);
    n = 0;
    while (interrupt_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Wait for the req pulse, check timing/src, ack d cycles later; optional
  // edge injection one cycle after the req
  task automatic serve(input int unsigned ch, input int unsigned exp_wait,
                       input int unsigned d, input logic [N-1:0] inj);
    int unsigned n;
    logic [63:0] exp_src;
    logic        stable;
    exp_src = src_base + 64'(ch);
    stable  = 1'b1;
    wait_req(n);
    check("req_latency", n, exp_wait);
    check("grant_src", interrupt_src, exp_src);
    rr_last = ch;
    for (int unsigned t = 0; t <= d; t++) begin
      interrupt_ack = (t == d);
      interrupt_i   = (t == 1) ? inj : '0;
      if (interrupt_src !== exp_src) stable = 1'b0;
      @(negedge clk);
      if (t == 0) check("req_one_cycle", interrupt_req, 1'b0);
    end
    interrupt_ack = 1'b0;
    interrupt_i   = '0;
    check("src_stable", stable, 1'b1);
  endtask

  task automatic expect_quiet(input string tag, input int unsigned cycles);
    int unsigned seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (interrupt_req === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  function automatic void build_order(input logic [N-1:0] m, input int unsigned last);
    order_q.delete();
    for (int unsigned s = 1; s <= N; s++) begin
      int unsigned c;
      c = (last + s) % N;
      if (m[c]) order_q.push_back(c);
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, kd, lo, hi;
    logic [N-1:0] m, en;
    int unsigned n;

    axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = 4'hF;
    axil.wvalid = 1'b0; axil.bready = 1'b1; axil.araddr = '0; axil.arvalid = 1'b0;
    axil.rready = 1'b1;
    ctl.awready = 1'b1; ctl.wready = 1'b1; ctl.bresp = 2'b00; ctl.bvalid = 1'b0;
    ctl.arready = 1'b1; ctl.rdata = '0; ctl.rresp = 2'b00; ctl.rvalid = 1'b0;

    do_reset(3);
    check("rst_req", interrupt_req, 1'b0);
    check("rst_src", interrupt_src, 64'h0);
    check("rst_ctx", interrupt_ctx, 9'h0);
    check("rst_hijack", axil.rdata, 32'h0);

    read_check("rd_type", BASE + 32'h10, 32'h0000ABCD);
    read_check("rd_release", BASE + 32'h14, 32'h00000001);
    read_check("rd_irq_en", BASE + 32'h24, 32'h0000000F);
    read_check("rd_context", BASE + 32'h20, 32'h0);
    read_check("rd_pend", BASE + 32'h28, 32'h0);
    #1;
    check("hijack_rvalid_low", axil.rdata, 32'h0);

    kd = $urandom;
    axi_read(BASE + 32'h2C, kd, rd);
    check("unmapped_pass", rd, kd);
    axi_read(BASE + 32'h10, 32'h0001_0000, rd);
    check("type_or_kernel", rd, 32'h0001_ABCD);

    axil.awaddr = 32'h1234_5678;
    ctl.bvalid  = 1'b1;
    ctl.bresp   = 2'b10;
    #1;
    check("awaddr_pass", ctl.awaddr, 32'h1234_5678);
    check("bvalid_pass", axil.bvalid, 1'b1);
    check("bresp_pass", axil.bresp, 2'b10);
    ctl.bvalid = 1'b0;
    ctl.bresp  = 2'b00;
    @(negedge clk);

    axi_write(BASE + 32'h20, 32'h0000_01A5, 1'b1, '0);
    check("ctx_split_write", interrupt_ctx, 9'h1A5);
    read_check("rd_context_w", BASE + 32'h20, 32'h0000_01A5);

    // Carry across the 32-bit boundary of the source address
    axi_write(BASE + 32'h1C, 32'h0, 1'b0, '0);
    axi_write(BASE + 32'h18, 32'hFFFF_FFFF, 1'b0, '0);
    src_base = 64'h0000_0000_FFFF_FFFF;
    pulse_irq(4'b0010);
    serve(1, 1, 3, '0);
    check("src_carry_abs", src_base + 64'd1, 64'h0000_0001_0000_0000);

    do_reset(1);
    lo = $urandom; hi = $urandom;
    axi_write(BASE + 32'h18, lo, 1'b0, '0);
    axi_write(BASE + 32'h1C, hi, 1'b1, '0);
    src_base = {hi, lo};
    pulse_irq(4'b1101);
    build_order(4'b1101, rr_last);
    check("order_len", order_q.size(), 3);
    foreach (order_q[i]) serve(order_q[i], 1, 3, '0);
    expect_quiet("rr_done_quiet", 6);
    read_check("rd_pend_after_rr", BASE + 32'h28, 32'h0);

    axi_write(BASE + 32'h24, 32'h0000_000B, 1'b0, '0);
    pulse_irq(4'b0100);
    expect_quiet("masked_no_req", 6);
    read_check("rd_pend_masked", BASE + 32'h28, 32'h4);
    axi_write(BASE + 32'h24, 32'h0000_000F, 1'b0, '0);
    serve(2, 1, 1, '0);

    pulse_irq(4'b0010);
    serve(1, 1, 3, 4'b0010);
    serve(1, 1, 0, '0);
    expect_quiet("reedge_quiet", 4);

    axi_write(BASE + 32'h24, 32'h0000_000D, 1'b0, '0);
    pulse_irq(4'b0010);
    expect_quiet("w1c_setup_quiet", 3);
    read_check("rd_pend_ch1", BASE + 32'h28, 32'h2);
    axi_write(BASE + 32'h28, 32'h2, 1'b0, 4'b0010);
    read_check("w1c_vs_edge", BASE + 32'h28, 32'h2);
    axi_write(BASE + 32'h28, 32'h2, 1'b0, '0);
    read_check("w1c_clears", BASE + 32'h28, 32'h0);
    axi_write(BASE + 32'h24, 32'h0000_000F, 1'b0, '0);
    expect_quiet("after_w1c_quiet", 4);

    // Reset while waiting for ack; in-flight src must ignore SRC_LO writes
    axi_write(BASE + 32'h1C, 32'h0000_000A, 1'b0, '0);
    axi_write(BASE + 32'h18, 32'h0000_0010, 1'b0, '0);
    axi_write(BASE + 32'h20, 32'h0000_0155, 1'b0, '0);
    src_base = 64'h0000_000A_0000_0010;
    pulse_irq(4'b0001);
    wait_req(n);
    check("wait_req_latency", n, 1);
    check("wait_src", interrupt_src, 64'h0000_000A_0000_0010);
    @(negedge clk);
    axi_write(BASE + 32'h18, 32'h0000_0999, 1'b0, '0);
    check("src_hold_in_wait", interrupt_src, 64'h0000_000A_0000_0010);
    check("ctx_before_rst", interrupt_ctx, 9'h155);
    do_reset(1);
    check("midwait_rst_req", interrupt_req, 1'b0);
    check("midwait_rst_src", interrupt_src, 64'h0);
    check("midwait_rst_ctx", interrupt_ctx, 9'h0);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    expect_quiet("stray_ack_quiet", 5);
    read_check("rst_pend_zero", BASE + 32'h28, 32'h0);
    read_check("rst_irq_en", BASE + 32'h24, 32'h0000000F);
    pulse_irq(4'b0101);
    serve(0, 1, 0, '0);
    serve(2, 1, 2, '0);

    for (int r = 0; r < 12; r++) begin
      lo = $urandom; hi = $urandom;
      axi_write(BASE + 32'h18, lo, 1'b0, '0);
      axi_write(BASE + 32'h1C, hi, 1'b0, '0);
      src_base = {hi, lo};
      en = N'($urandom_range(0, 15));
      m  = N'($urandom_range(1, 15));
      axi_write(BASE + 32'h24, 32'(en), 1'b0, '0);
      pulse_irq(m);
      build_order(m & en, rr_last);
      foreach (order_q[i]) serve(order_q[i], 1, $urandom_range(0, 4), '0);
      expect_quiet("rand_masked_quiet", 3);
      read_check("rand_pend_masked", BASE + 32'h28, 32'(m & ~en));
      axi_write(BASE + 32'h24, 32'h0000_000F, 1'b0, '0);
      build_order(m & ~en, rr_last);
      foreach (order_q[i]) serve(order_q[i], 1, $urandom_range(0, 4), '0);
      expect_quiet("rand_final_quiet", 3);
      read_check("rand_pend_zero", BASE + 32'h28, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
